// File: rtl/l1_cache_responder.sv
// rtl/l1_cache_responder.sv - direct-mapped write-back write-allocate L1 cache
// Answers CPU word requests; misses evict a dirty victim, then refill a 256-bit line.
module l1_cache_responder #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int S_TAG  = 32 - S_INDEX - S_OFFSET;
  localparam int N_SETS = 2 ** S_INDEX;
  localparam int S_WSEL = S_OFFSET - 2;

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_next;

  logic [N_SETS-1:0] valid_q;
  logic [N_SETS-1:0] dirty_q;
  logic [S_TAG-1:0]  tag_q  [N_SETS];
  logic [255:0]      data_q [N_SETS];

  logic [S_TAG-1:0]   req_tag;
  logic [S_INDEX-1:0] req_index;
  logic [S_WSEL-1:0]  req_wsel;
  logic [7:0]         word_lsb;
  logic               unused_addr_lsb;

  assign req_tag         = mem_address[31 -: S_TAG];
  assign req_index       = mem_address[S_OFFSET +: S_INDEX];
  assign req_wsel        = mem_address[2 +: S_WSEL];
  assign word_lsb        = 8'({req_wsel, 5'b00000});
  assign unused_addr_lsb = ^mem_address[1:0];

  logic         req_any;
  logic         is_write;
  logic         hit;
  logic         victim_dirty;
  logic [S_TAG-1:0] tag_rd;
  logic [255:0] line_rd;
  logic [31:0]  word_rd;
  logic [31:0]  word_merged;
  logic [255:0] line_merged;

  // A simultaneous read and write is handled as a write.
  assign req_any      = mem_read | mem_write;
  assign is_write     = mem_write;
  assign tag_rd       = tag_q[req_index];
  assign line_rd      = data_q[req_index];
  assign word_rd      = line_rd[word_lsb +: 32];
  assign hit          = valid_q[req_index] && (tag_rd == req_tag);
  assign victim_dirty = valid_q[req_index] && dirty_q[req_index];

  always_comb begin
    word_merged = word_rd;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) word_merged[b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  always_comb begin
    line_merged = line_rd;
    line_merged[word_lsb +: 32] = word_merged;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req_any) state_next = CHECK;
      end
      CHECK: begin
        if (!req_any || hit) state_next = IDLE;
        else if (victim_dirty) state_next = WRITEBACK;
        else state_next = ALLOCATE;
      end
      WRITEBACK: begin
        if (pmem_resp) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        if (pmem_resp) state_next = CHECK;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = line_rd;
    unique case (state)
      CHECK: begin
        if (req_any && hit) begin
          mem_resp = 1'b1;
          if (!is_write) mem_rdata = word_rd;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_rd, req_index, {S_OFFSET{1'b0}}};
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_index, {S_OFFSET{1'b0}}};
      end
      default: ;
    endcase
  end

  // Status bits reset; a reset during a refill leaves the line invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state == CHECK && req_any && hit && is_write) begin
      dirty_q[req_index] <= 1'b1;
    end else if (state == ALLOCATE && pmem_resp) begin
      valid_q[req_index] <= 1'b1;
      dirty_q[req_index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CHECK && req_any && hit && is_write) begin
        data_q[req_index] <= line_merged;
      end else if (state == ALLOCATE && pmem_resp) begin
        data_q[req_index] <= pmem_rdata;
        tag_q[req_index]  <= req_tag;
      end
    end
  end

endmodule

// File: tb/tb_l1_cache_responder.sv
// tb/tb_l1_cache_responder.sv - randomized self-checking bench for l1_cache_responder
module tb_l1_cache_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address, mem_wdata, mem_rdata;
  logic         mem_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  l1_cache_responder dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } ev_t;

  // Backing memory image and the CPU-visible image of lines modified in the cache.
  logic [255:0] pm_line  [logic [31:0]];
  logic [255:0] cpu_line [logic [31:0]];
  ev_t          ev_q[$];
  bit           withhold = 1'b0;
  bit           mon_on = 1'b0;

  // Which line each set holds, and whether it holds unwritten-back data.
  logic [31:0] res_la [8];
  bit          res_v  [8];
  bit          res_d  [8];

  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = la ^ (32'h9E37_0000 + 32'(i));
    return l;
  endfunction

  function automatic logic [255:0] pm_get(input logic [31:0] la);
    if (pm_line.exists(la)) return pm_line[la];
    return init_line(la);
  endfunction

  function automatic logic [255:0] cpu_get(input logic [31:0] la);
    if (cpu_line.exists(la)) return cpu_line[la];
    return pm_get(la);
  endfunction

  // Physical memory: random response delay, one-cycle pmem_resp pulse.
  initial begin
    int cd;
    cd = -1;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (!(pmem_read || pmem_write) || (withhold && pmem_read)) begin
        cd = -1;
      end else begin
        if (cd < 0) cd = int'($urandom_range(0, 3));
        if (cd == 0) begin
          if (pmem_write) begin
            pm_line[pmem_address] = pmem_wdata;
            ev_q.push_back('{1'b1, pmem_address, pmem_wdata});
          end else begin
            pmem_rdata = pm_get(pmem_address);
            ev_q.push_back('{1'b0, pmem_address, 256'h0});
          end
          pmem_resp = 1'b1;
          cd = -1;
        end else begin
          cd--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      check("pmem_excl", pmem_read & pmem_write, 1'b0);
      if (!pmem_read && !pmem_write) check("pmem_addr_idle", pmem_address, 32'h0);
      else check("pmem_addr_align", pmem_address[4:0], 5'h0);
      if (!mem_resp) check("rdata_idle", mem_rdata, 32'h0);
    end
  end

  task automatic cpu_op(input bit wr, input bit both, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc);
    logic [31:0]  la;
    logic [255:0] l;
    logic [31:0]  w;
    int           s, wi, n;
    bit           hit;
    ev_t          exp_q[$];
    la  = {addr[31:5], 5'b0};
    s   = int'(addr[7:5]);
    wi  = int'(addr[4:2]);
    hit = res_v[s] && (res_la[s] == la);
    if (!hit) begin
      if (res_v[s] && res_d[s]) exp_q.push_back('{1'b1, res_la[s], cpu_get(res_la[s])});
      exp_q.push_back('{1'b0, la, 256'h0});
    end
    ev_q.delete();
    mem_address     = addr;
    mem_wdata       = wd;
    mem_byte_enable = be;
    mem_write       = wr;
    mem_read        = !wr || both;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!mem_resp && cyc < 300);
    check("resp_seen", mem_resp, 1'b1);
    rd = mem_rdata;
    @(posedge clk); #1;
    check("resp_one_cycle", mem_resp, 1'b0);
    mem_read  = 1'b0;
    mem_write = 1'b0;

    l = cpu_get(la);
    w = l[wi*32 +: 32];
    if (wr) begin
      check("wr_rdata_zero", rd, 32'h0);
      for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      l[wi*32 +: 32] = w;
      cpu_line[la] = l;
    end else begin
      check("rd_data", rd, w);
    end
    if (hit) check("hit_latency", cyc, 1);
    else     check("miss_latency_min", cyc >= 3, 1'b1);
    check("ev_count", ev_q.size(), exp_q.size());
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("ev_kind", ev_q[i].wr, exp_q[i].wr);
      check("ev_addr", ev_q[i].addr, exp_q[i].addr);
      if (exp_q[i].wr) check("ev_wb_data", ev_q[i].data, exp_q[i].data);
    end
    res_d[s]  = wr || (hit && res_d[s]);
    res_v[s]  = 1'b1;
    res_la[s] = la;
  endtask

  initial begin
    logic [31:0] rd, a;
    int          cyc;
    bit          wr;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 4'h0; mem_address = '0; mem_wdata = '0;
    for (int i = 0; i < 8; i++) begin res_v[i] = 1'b0; res_d[i] = 1'b0; res_la[i] = '0; end
    pm_line[32'h100] = {32'h0000_2222, 32'h0000_1111, 32'h0000_FFFF, 32'h0000_EEEE,
                        32'h0000_DDDD, 32'h0000_CCCC, 32'h0000_BBBB, 32'h0000_AAAA};
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_resp", mem_resp, 1'b0);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_pmem_address", pmem_address, 32'h0);
    rst_n = 1'b1;
    mon_on = 1'b1;
    @(posedge clk); #1;

    cpu_op(1'b0, 1'b0, 32'h0000_0104, 4'h0, 32'h0, rd, cyc);
    check("tp1_alloc_addr", (ev_q.size() == 1 && !ev_q[0].wr) ? ev_q[0].addr : 32'hFFFF_FFFF, 32'h0000_0100);
    check("tp1_rdata", rd, 32'h0000_BBBB);

    cpu_op(1'b0, 1'b0, 32'h0000_0104, 4'h0, 32'h0, rd, cyc);
    check("tp2_latency", cyc, 1);
    check("tp2_no_pmem", ev_q.size(), 0);

    cpu_op(1'b1, 1'b0, 32'h0000_0104, 4'b0011, 32'h1234_5678, rd, cyc);
    cpu_op(1'b0, 1'b0, 32'h0000_0104, 4'h0, 32'h0, rd, cyc);
    check("tp3_merged", rd, 32'h0000_5678);

    cpu_op(1'b0, 1'b0, 32'h0000_1104, 4'h0, 32'h0, rd, cyc);
    check("tp4_ev_count", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      check("tp4_wb_first", ev_q[0].wr, 1'b1);
      check("tp4_wb_addr", ev_q[0].addr, 32'h0000_0100);
      check("tp4_wb_word1", ev_q[0].data[63:32], 32'h0000_5678);
      check("tp4_alloc_addr", ev_q[1].addr, 32'h0000_1100);
    end

    cpu_op(1'b0, 1'b0, 32'h0000_0200, 4'h0, 32'h0, rd, cyc);
    check("tp5_alloc_only", ev_q.size(), 1);

    // Dirty set 0, then reset while its refill is stalled.
    cpu_op(1'b1, 1'b1, 32'h0000_0208, 4'b1111, 32'hCAFE_F00D, rd, cyc);
    withhold = 1'b1;
    mem_address = 32'h0000_3304;
    mem_read = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!pmem_read && cyc < 100);
    check("rst_alloc_seen", pmem_read, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_pmem_read", pmem_read, 1'b0);
    check("rst_mid_pmem_write", pmem_write, 1'b0);
    check("rst_mid_mem_resp", mem_resp, 1'b0);
    mem_read = 1'b0;
    rst_n = 1'b1;
    withhold = 1'b0;
    for (int i = 0; i < 8; i++) begin res_v[i] = 1'b0; res_d[i] = 1'b0; end
    cpu_line.delete();
    @(posedge clk); #1;
    cpu_op(1'b0, 1'b0, 32'h0000_3304, 4'h0, 32'h0, rd, cyc);
    check("rst_remiss", (ev_q.size() == 1 && !ev_q[0].wr) ? ev_q[0].addr : 32'hFFFF_FFFF, 32'h0000_3300);

    for (int k = 0; k < 250; k++) begin
      a = {22'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      wr = ($urandom_range(0, 1) == 1);
      cpu_op(wr, ($urandom_range(0, 3) == 0), a, 4'($urandom_range(0, 15)), $urandom, rd, cyc);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
